// File: rtl/clarvi_arb_pkg.sv
// Shared types for the clarvi memory arbiter: port owner IDs, lock FSM states
// and the all-bytes enable used for instruction fetches.
package clarvi_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D,
    OWN_X
  } owner_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/clarvi_mem_arbiter_if.sv
// Bus bundle between the instruction, data and DMA requesters, the arbiter and
// the shared single-port memory. The arbiter uses the slave view.
interface clarvi_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);

  logic [ADDR_WIDTH-1:0] i_address;
  logic                  i_read;
  logic [31:0]           i_readdata;
  logic                  i_waitrequest;
  logic                  i_readdatavalid;

  logic [ADDR_WIDTH-1:0] d_address;
  logic [3:0]            d_byteenable;
  logic                  d_read;
  logic                  d_write;
  logic [31:0]           d_writedata;
  logic [31:0]           d_readdata;
  logic                  d_waitrequest;
  logic                  d_readdatavalid;

  logic [ADDR_WIDTH-1:0] x_address;
  logic [3:0]            x_byteenable;
  logic                  x_read;
  logic                  x_write;
  logic [31:0]           x_writedata;
  logic                  x_lock;
  logic [31:0]           x_readdata;
  logic                  x_waitrequest;
  logic                  x_readdatavalid;

  logic                  cpu_mem_pause;

  logic [ADDR_WIDTH-1:0] m_address;
  logic [3:0]            m_byteenable;
  logic                  m_read;
  logic                  m_write;
  logic [31:0]           m_writedata;
  logic [31:0]           m_readdata;
  logic                  m_waitrequest;

  modport slave (
    input  i_address, i_read,
    output i_readdata, i_waitrequest, i_readdatavalid,
    input  d_address, d_byteenable, d_read, d_write, d_writedata,
    output d_readdata, d_waitrequest, d_readdatavalid,
    input  x_address, x_byteenable, x_read, x_write, x_writedata, x_lock,
    output x_readdata, x_waitrequest, x_readdatavalid,
    output cpu_mem_pause,
    output m_address, m_byteenable, m_read, m_write, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport master (
    output i_address, i_read,
    input  i_readdata, i_waitrequest, i_readdatavalid,
    output d_address, d_byteenable, d_read, d_write, d_writedata,
    input  d_readdata, d_waitrequest, d_readdatavalid,
    output x_address, x_byteenable, x_read, x_write, x_writedata, x_lock,
    input  x_readdata, x_waitrequest, x_readdatavalid,
    input  cpu_mem_pause,
    input  m_address, m_byteenable, m_read, m_write, m_writedata,
    output m_readdata, m_waitrequest
  );

endinterface

// File: rtl/clarvi_arb_starve.sv
// Saturating count of consecutive cycles the instruction port was denied;
// force_i tells the grant logic to let instruction fetch win.
module clarvi_arb_starve #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic i_done,
  output logic force_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!i_req || i_done) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_i = (cnt == LIMIT);

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Three-way arbiter (instruction, data, DMA) in front of one 1-cycle-latency
// memory, with starvation relief and a DMA lock. Macro CLARVI_ARB_PERF_EN adds
// per-port stall counters.
module clarvi_mem_arbiter
  import clarvi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  clarvi_mem_arbiter_if.slave   bus
`ifdef CLARVI_ARB_PERF_EN
  ,
  output logic [31:0]           perf_i_stall,
  output logic [31:0]           perf_d_stall,
  output logic [31:0]           perf_x_stall
`endif
);

  owner_t     gnt;
  owner_t     owner_q;
  arb_state_t state_q;
  arb_state_t state_d;

  logic i_req, d_req, x_req;
  logic force_i;
  logic done, rd_done;
  logic i_wait, d_wait, x_wait;
  logic pause;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [3:0]            be_mux;
  logic                  rd_mux, wr_mux;
  logic [31:0]           wd_mux;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;
  assign x_req = bus.x_read | bus.x_write;

  clarvi_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .i_req   (i_req),
    .i_done  ((gnt == OWN_I) && !bus.m_waitrequest),
    .force_i (force_i)
  );

  // Grant is held at OWN_NONE during reset so m_* and pause read as idle.
  always_comb begin
    gnt = OWN_NONE;
    if (!reset) begin
      gnt = OWN_NONE;
    end else if (state_q == ARB_LOCKED) begin
      if (x_req) gnt = OWN_X;
    end else if (force_i && i_req) begin
      gnt = OWN_I;
    end else if (x_req) begin
      gnt = OWN_X;
    end else if (d_req) begin
      gnt = OWN_D;
    end else if (i_req) begin
      gnt = OWN_I;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    addr_mux = '0;
    be_mux   = '0;
    rd_mux   = 1'b0;
    wr_mux   = 1'b0;
    wd_mux   = '0;
    case (gnt)
      OWN_I: begin
        addr_mux = bus.i_address;
        be_mux   = BE_ALL;
        rd_mux   = 1'b1;
      end
      OWN_D: begin
        addr_mux = bus.d_address;
        be_mux   = bus.d_byteenable;
        wr_mux   = bus.d_write;
        rd_mux   = bus.d_read & ~bus.d_write;
        wd_mux   = bus.d_writedata;
      end
      OWN_X: begin
        addr_mux = bus.x_address;
        be_mux   = bus.x_byteenable;
        wr_mux   = bus.x_write;
        rd_mux   = bus.x_read & ~bus.x_write;
        wd_mux   = bus.x_writedata;
      end
      default: ;
    endcase
  end

  assign bus.m_address    = addr_mux;
  assign bus.m_byteenable = be_mux;
  assign bus.m_read       = rd_mux;
  assign bus.m_write      = wr_mux;
  assign bus.m_writedata  = wd_mux;

  // Winner follows the memory stall, a requesting loser stalls, idle is free.
  always_comb begin
    i_wait = 1'b1;
    d_wait = 1'b1;
    x_wait = 1'b1;
    if (reset) begin
      i_wait = (gnt == OWN_I) ? bus.m_waitrequest : i_req;
      d_wait = (gnt == OWN_D) ? bus.m_waitrequest : d_req;
      x_wait = (gnt == OWN_X) ? bus.m_waitrequest : x_req;
    end
  end

  assign bus.i_waitrequest = i_wait;
  assign bus.d_waitrequest = d_wait;
  assign bus.x_waitrequest = x_wait;

  assign done    = (gnt != OWN_NONE) && !bus.m_waitrequest;
  assign rd_done = done && rd_mux;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= rd_done ? gnt : OWN_NONE;
    end
  end

  assign bus.i_readdata      = bus.m_readdata;
  assign bus.d_readdata      = bus.m_readdata;
  assign bus.x_readdata      = bus.m_readdata;
  assign bus.i_readdatavalid = (owner_q == OWN_I);
  assign bus.d_readdatavalid = (owner_q == OWN_D);
  assign bus.x_readdatavalid = (owner_q == OWN_X);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pause   = 1'b0;
    case (state_q)
      ARB_OPEN: begin
        pause = (gnt == OWN_X);
        if ((gnt == OWN_X) && done && bus.x_lock) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        pause = 1'b1;
        if (!bus.x_lock && !x_req) state_d = ARB_OPEN;
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  assign bus.cpu_mem_pause = pause;

`ifdef CLARVI_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_i_stall <= '0;
      perf_d_stall <= '0;
      perf_x_stall <= '0;
    end else begin
      if (i_req && i_wait && (perf_i_stall != 32'hFFFF_FFFF)) perf_i_stall <= perf_i_stall + 32'd1;
      if (d_req && d_wait && (perf_d_stall != 32'hFFFF_FFFF)) perf_d_stall <= perf_d_stall + 32'd1;
      if (x_req && x_wait && (perf_x_stall != 32'hFFFF_FFFF)) perf_x_stall <= perf_x_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Self-checking bench for clarvi_mem_arbiter: directed scenarios with a
// read-return scoreboard fed at stimulus time and drained by a monitor.
module tb_clarvi_mem_arbiter;
  import clarvi_arb_pkg::*;

  localparam int AW = 14;
  localparam int SL = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  clarvi_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef CLARVI_ARB_PERF_EN
  logic [31:0] perf_i_stall, perf_d_stall, perf_x_stall;
`endif

  clarvi_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef CLARVI_ARB_PERF_EN
    ,
    .perf_i_stall (perf_i_stall),
    .perf_d_stall (perf_d_stall),
    .perf_x_stall (perf_x_stall)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  localparam logic [2:0] P_I = 3'b100;
  localparam logic [2:0] P_D = 3'b010;
  localparam logic [2:0] P_X = 3'b001;

  typedef struct {
    logic [2:0]  port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
    return 32'h5A00_0000 | (32'(a) * 32'd7);
  endfunction

  always @(posedge clock) cyc++;

  // Memory model: fixed one-cycle read latency, captures only when not stalled.
  always @(posedge clock)
    if (bus.m_read && !bus.m_waitrequest) bus.m_readdata <= mem_data(bus.m_address);

  task automatic push(input logic [2:0] port, input logic [AW-1:0] a);
    exp_t e;
    e.port = port;
    e.data = mem_data(a);
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  // Read-return monitor.
  logic [2:0] mon_v;
  exp_t       mon_e;
  always @(negedge clock) begin
    if (reset) begin
      mon_v = {bus.i_readdatavalid, bus.d_readdatavalid, bus.x_readdatavalid};
      if (mon_v != 3'b000) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rdv_unexpected cyc=%0d valid=%b required=000", cyc, mon_v);
        end else begin
          mon_e = sb.pop_front();
          if (mon_v !== mon_e.port || cyc != mon_e.cyc ||
              {bus.i_readdata, bus.d_readdata, bus.x_readdata} !== {3{mon_e.data}}) begin
            miscompares++;
            $display("FAIL rdv_return cyc=%0d valid=%b data=%h required cyc=%0d valid=%b data=%h",
                     cyc, mon_v, bus.d_readdata, mon_e.cyc, mon_e.port, mon_e.data);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL rdv_missing cyc=%0d valid=000 required=%b at cyc=%0d", cyc, sb[0].port, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.x_read = 1'b0; bus.x_write = 1'b0; bus.x_lock = 1'b0;
    bus.m_waitrequest = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({bus.i_waitrequest, bus.d_waitrequest, bus.x_waitrequest,
         bus.i_readdatavalid, bus.d_readdatavalid, bus.x_readdatavalid,
         bus.m_read, bus.m_write, bus.m_byteenable, bus.cpu_mem_pause} !== 13'b111_000_00_0000_0) begin
      miscompares++;
      $display("FAIL %s wait=%b rdv=%b rd=%b wr=%b be=%h pause=%b required wait=111 rdv=000 rd/wr/be/pause=0",
               tag, {bus.i_waitrequest, bus.d_waitrequest, bus.x_waitrequest},
               {bus.i_readdatavalid, bus.d_readdatavalid, bus.x_readdatavalid},
               bus.m_read, bus.m_write, bus.m_byteenable, bus.cpu_mem_pause);
    end
  endtask

  task automatic test_reset();
    bus.i_address = '0; bus.d_address = '0; bus.x_address = '0;
    bus.d_byteenable = 4'h0; bus.x_byteenable = 4'h0;
    bus.d_writedata = '0; bus.x_writedata = '0; bus.m_readdata = '0;
    idle_all();
    bus.i_read = 1'b1; bus.d_read = 1'b1; bus.x_write = 1'b1;
    @(negedge clock);
    check_reset_values("reset_values");
    tick();
    idle_all();
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({bus.i_waitrequest, bus.d_waitrequest, bus.x_waitrequest, bus.m_read, bus.m_write} !== 5'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset wait=%b rd=%b wr=%b required all 0",
               {bus.i_waitrequest, bus.d_waitrequest, bus.x_waitrequest}, bus.m_read, bus.m_write);
    end
    tick();
  endtask

  task automatic test_d_vs_i();
    bus.d_write = 1'b1; bus.d_address = 14'h20; bus.d_writedata = 32'h1111_2222; bus.d_byteenable = 4'h3;
    bus.i_read = 1'b1; bus.i_address = 14'h30;
    @(negedge clock);
    vectors++;
    if ({bus.m_write, bus.m_read, bus.m_address, bus.m_byteenable, bus.m_writedata,
         bus.i_waitrequest, bus.d_waitrequest} !== {1'b1, 1'b0, 14'h20, 4'h3, 32'h1111_2222, 2'b10}) begin
      miscompares++;
      $display("FAIL dwr_vs_i wr=%b rd=%b addr=%h be=%h wd=%h iw=%b dw=%b required wr=1 addr=20 be=3 wd=11112222 iw=1 dw=0",
               bus.m_write, bus.m_read, bus.m_address, bus.m_byteenable, bus.m_writedata,
               bus.i_waitrequest, bus.d_waitrequest);
    end
    tick();
    bus.d_write = 1'b0;
    push(P_I, 14'h30);
    @(negedge clock);
    vectors++;
    if ({bus.m_read, bus.m_address, bus.m_byteenable, bus.i_waitrequest} !== {1'b1, 14'h30, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL i_after_d rd=%b addr=%h be=%h iw=%b required rd=1 addr=30 be=f iw=0",
               bus.m_read, bus.m_address, bus.m_byteenable, bus.i_waitrequest);
    end
    tick();
    bus.d_read = 1'b1; bus.d_address = 14'h24; bus.d_byteenable = 4'hF; bus.i_address = 14'h34;
    push(P_D, 14'h24);
    @(negedge clock);
    vectors++;
    if ({bus.m_read, bus.m_address, bus.i_waitrequest, bus.d_waitrequest} !== {1'b1, 14'h24, 2'b10}) begin
      miscompares++;
      $display("FAIL drd_vs_i rd=%b addr=%h iw=%b dw=%b required rd=1 addr=24 iw=1 dw=0",
               bus.m_read, bus.m_address, bus.i_waitrequest, bus.d_waitrequest);
    end
    tick();
    bus.d_read = 1'b0;
    push(P_I, 14'h34);
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_starve();
    logic exp_i;
    logic [AW-1:0] exp_a;
    bus.d_read = 1'b1; bus.d_address = 14'h40;
    bus.i_read = 1'b1; bus.i_address = 14'h50;
    for (int k = 1; k <= 10; k++) begin
      exp_i = (k % (SL + 1)) == 0;
      exp_a = exp_i ? 14'h50 : 14'h40;
      push(exp_i ? P_I : P_D, exp_a);
      @(negedge clock);
      vectors++;
      if ({bus.m_read, bus.m_address, bus.i_waitrequest, bus.d_waitrequest} !== {1'b1, exp_a, !exp_i, exp_i}) begin
        miscompares++;
        $display("FAIL starve_cycle%0d addr=%h iw=%b dw=%b required addr=%h iw=%b dw=%b",
                 k, bus.m_address, bus.i_waitrequest, bus.d_waitrequest, exp_a, !exp_i, exp_i);
      end
      tick();
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_lock();
    bus.x_write = 1'b1; bus.x_lock = 1'b1; bus.x_address = 14'h10;
    bus.x_writedata = 32'hDEAD_BEEF; bus.x_byteenable = 4'hF;
    bus.d_read = 1'b1; bus.d_address = 14'h44;
    @(negedge clock);
    vectors++;
    if ({bus.m_write, bus.m_address, bus.m_writedata, bus.x_waitrequest, bus.d_waitrequest, bus.cpu_mem_pause}
        !== {1'b1, 14'h10, 32'hDEAD_BEEF, 3'b011}) begin
      miscompares++;
      $display("FAIL lock_write wr=%b addr=%h wd=%h xw=%b dw=%b pause=%b required wr=1 addr=10 wd=deadbeef xw=0 dw=1 pause=1",
               bus.m_write, bus.m_address, bus.m_writedata, bus.x_waitrequest, bus.d_waitrequest, bus.cpu_mem_pause);
    end
    tick();
    bus.x_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.x_lock = 1'b0;
      @(negedge clock);
      vectors++;
      if ({bus.d_waitrequest, bus.cpu_mem_pause, bus.m_read, bus.m_write} !== 4'b1100) begin
        miscompares++;
        $display("FAIL lock_hold%0d dw=%b pause=%b rd=%b wr=%b required dw=1 pause=1 rd=0 wr=0",
                 k, bus.d_waitrequest, bus.cpu_mem_pause, bus.m_read, bus.m_write);
      end
      tick();
    end
    push(P_D, 14'h44);
    @(negedge clock);
    vectors++;
    if ({bus.d_waitrequest, bus.cpu_mem_pause, bus.m_read, bus.m_address} !== {3'b001, 14'h44}) begin
      miscompares++;
      $display("FAIL lock_release dw=%b pause=%b rd=%b addr=%h required dw=0 pause=0 rd=1 addr=44",
               bus.d_waitrequest, bus.cpu_mem_pause, bus.m_read, bus.m_address);
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.d_read = 1'b1; bus.d_address = 14'h4;
    push(P_D, 14'h4);
    tick();
    bus.d_read = 1'b0; bus.i_read = 1'b1; bus.i_address = 14'h8;
    push(P_I, 14'h8);
    tick();
    bus.i_read = 1'b0; bus.x_read = 1'b1; bus.x_address = 14'hC; bus.x_lock = 1'b0;
    push(P_X, 14'hC);
    @(negedge clock);
    vectors++;
    if ({bus.m_read, bus.m_address, bus.cpu_mem_pause} !== {1'b1, 14'hC, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_x_grant rd=%b addr=%h pause=%b required rd=1 addr=c pause=1",
               bus.m_read, bus.m_address, bus.cpu_mem_pause);
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_mem_wait();
    bus.d_write = 1'b1; bus.d_address = 14'h60; bus.d_writedata = 32'h1234_5678; bus.d_byteenable = 4'hF;
    bus.m_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.m_waitrequest = 1'b0;
      @(negedge clock);
      vectors++;
      if ({bus.d_waitrequest, bus.m_write, bus.m_address, bus.m_writedata, bus.m_byteenable}
          !== {(k != 3), 1'b1, 14'h60, 32'h1234_5678, 4'hF}) begin
        miscompares++;
        $display("FAIL memwait_wr%0d dw=%b wr=%b addr=%h wd=%h be=%h required dw=%b wr=1 addr=60 wd=12345678 be=f",
                 k, bus.d_waitrequest, bus.m_write, bus.m_address, bus.m_writedata, bus.m_byteenable, (k != 3));
      end
      tick();
    end
    bus.d_write = 1'b0; bus.d_read = 1'b1; bus.d_address = 14'h64;
    bus.m_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus.m_waitrequest = 1'b0;
        push(P_D, 14'h64);
      end
      @(negedge clock);
      vectors++;
      if (bus.d_waitrequest !== (k != 2)) begin
        miscompares++;
        $display("FAIL memwait_rd%0d dw=%b required %b", k, bus.d_waitrequest, (k != 2));
      end
      tick();
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.d_read = 1'b1; bus.d_address = 14'h70;
    @(negedge clock);
    vectors++;
    if ({bus.m_read, bus.m_address, bus.d_waitrequest} !== {1'b1, 14'h70, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_grant rd=%b addr=%h dw=%b required rd=1 addr=70 dw=0",
               bus.m_read, bus.m_address, bus.d_waitrequest);
    end
    tick();
    reset = 1'b0;
    bus.i_read = 1'b1; bus.x_write = 1'b1;
    #1;
    check_reset_values("rstmid_async");
    @(negedge clock);
    check_reset_values("rstmid_hold");
    tick();
    idle_all();
    reset = 1'b1;
    tick();
    bus.x_write = 1'b1; bus.x_lock = 1'b1; bus.x_address = 14'h18;
    tick();
    bus.x_write = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.cpu_mem_pause !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_locked pause=%b required 1", bus.cpu_mem_pause);
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.cpu_mem_pause !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_unlock_async pause=%b required 0", bus.cpu_mem_pause);
    end
    tick();
    reset = 1'b1;
    bus.d_read = 1'b1; bus.d_address = 14'h74;
    push(P_D, 14'h74);
    @(negedge clock);
    vectors++;
    if ({bus.d_waitrequest, bus.m_read, bus.m_address, bus.cpu_mem_pause} !== {2'b01, 14'h74, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_open dw=%b rd=%b addr=%h pause=%b required dw=0 rd=1 addr=74 pause=0",
               bus.d_waitrequest, bus.m_read, bus.m_address, bus.cpu_mem_pause);
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_d_vs_i();
    test_starve();
    test_lock();
    test_back_to_back();
    test_mem_wait();
    test_reset_mid();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clarvi_mem_arbiter.md
Name: clarvi_mem_arbiter

Overview:
Shares one single-port, fixed 1-cycle-read-latency Avalon-MM memory between the core's instruction port, the core's data port and the processing element's DMA/network-interface port. It sits between the clarvi Avalon wrapper and the local PE memory. It grants one request per cycle, stalls losers via waitrequest and steers readdatavalid back to the issuing port. A starvation counter guarantees forward progress of instruction fetch. A lock FSM lets DMA hold the memory for multi-word transfers.

Parameters:
ADDR_WIDTH, 14, word address width on every port
STARVE_LIMIT, 4, consecutive denied instr cycles before instr is forced to win; range 1..15

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_address  in  ADDR_WIDTH  instruction port address
i_read  in  1  instruction read request
i_readdata  out  32  instruction read data
i_waitrequest  out  1  instruction stall
i_readdatavalid  out  1  instruction data valid
d_address  in  ADDR_WIDTH  data port address
d_byteenable  in  4  data byte enables
d_read / d_write  in  1 each  data requests, mutually exclusive
d_writedata  in  32  data write data
d_readdata  out  32  data read data
d_waitrequest  out  1  data stall
d_readdatavalid  out  1  data valid
x_address, x_byteenable, x_read, x_write, x_writedata  in  ADDR_WIDTH/4/1/1/32  DMA port request
x_lock  in  1  DMA requests exclusive ownership
x_readdata  out  32  DMA read data
x_waitrequest, x_readdatavalid  out  1 each  DMA stall / valid
cpu_mem_pause  out  1  high while DMA owns memory (drives clarvi pause)
m_address, m_byteenable, m_read, m_write, m_writedata  out  ADDR_WIDTH/4/1/1/32  memory master
m_readdata  in  32  memory read data
m_waitrequest  in  1  memory stall

Behaviour:
- Reset values: all waitrequest outputs 1; readdatavalid 0; m_read/m_write 0; m_byteenable 0; cpu_mem_pause 0; starve counter 0; FSM OPEN; owner pipe empty.
- Request present: i_read; d_read|d_write; x_read|x_write.
- Grant is combinational, one winner per cycle:
  - FSM LOCKED: only X is eligible.
  - Otherwise: X > D > I.
  - Exception: I wins if starve_cnt == STARVE_LIMIT.
- Winner's request drives m_*. Instr accesses use byteenable 4'hF.
- Loser with a request: waitrequest = 1. Winner: waitrequest = m_waitrequest. Idle port: waitrequest = 0.
- Access completes when granted & !m_waitrequest.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle I requests and does not complete. Clears when I completes or I does not request.
- Read return: on a completed read, the owner ID (I/D/X) is registered. The next cycle, that port's readdatavalid = 1. readdata = m_readdata is broadcast to all three ports; only the owner sees valid. Back-to-back reads from different owners are legal.
- Lock FSM:
  - OPEN -> LOCKED when X completes an access with x_lock = 1.
  - LOCKED -> OPEN on the first cycle x_lock = 0 and no X request.
  - cpu_mem_pause = 1 in LOCKED, and in OPEN whenever X is granted.
- Simultaneous events:
  - X and starved I in OPEN: I wins. Starvation overrides DMA only when not LOCKED.
  - d_read and d_write both high: illegal; treated as write.
- Reset mid-operation: an outstanding readdatavalid is dropped. FSM returns to OPEN.

Optional Feature:
Macro CLARVI_ARB_PERF_EN.
- Defined: adds outputs perf_i_stall, perf_d_stall, perf_x_stall (32 bits each). Each counts cycles its port requested but waitrequest = 1. Counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package clarvi_arb_pkg holds:
  - typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_X} owner_t
  - typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t
  - localparam BE_ALL = 4'hF
- One sub-module, clarvi_arb_starve, holds the saturating starve counter and its force_i output.
- Grant logic, owner pipe and FSM stay in the top module.

Test Plan:
- D write and I read in the same cycle, m_waitrequest = 0: D granted, i_waitrequest = 1. Next cycle I granted at its address. Reads return d/i_readdatavalid exactly 1 cycle after each grant.
- Continuous d_read for 10 cycles with i_read held, STARVE_LIMIT = 4: I wins on cycle 5. Counter clears, and D resumes on cycle 6.
- x_write with x_lock = 1 (addr 0x10, data 0xDEADBEEF), then x_lock held for 3 idle cycles with d_read pending: d_waitrequest = 1 and cpu_mem_pause = 1 throughout. The lock releases 1 cycle after x_lock drops, then D is granted.
- Back-to-back grants D read (0x4), I read (0x8), X read (0xC): readdatavalid pulses on D, I, X in consecutive cycles, each with the matching m_readdata.
- m_waitrequest held high 3 cycles during a granted D write: d_waitrequest = 1 for 3 cycles and m_* stable. Completion happens on the 4th cycle.
- reset asserted the cycle after a granted D read: d_readdatavalid stays 0. All outputs are at reset values asynchronously.
